// File: rtl/pie_encoder.sv
// PIE forward-link encoder: emits delimiter, Data-0, RTcal, an optional TRcal,
// then one PIE symbol per command bit on out_mod.
//
// Handshake: in_rdy is a registered strobe, high for exactly one cycle, which
// is the last cycle of the symbol before the next bit is needed. A bit
// transfers when in_vld && in_rdy in that cycle. in_vld low in that cycle is
// an underrun: the frame is aborted with a one-cycle err pulse.
//
// All outputs are registered. They are computed from next-state values, so
// out_mod, busy and in_rdy describe the same cycle as state_q/cnt_q.
module pie_encoder #(
  parameter int CNT_WIDTH = 8,
  parameter int TARI      = 8,
  parameter int DATA1     = 14,
  parameter int PW        = 4,
  parameter int DELIM     = 6,
  parameter int TRCAL     = 36
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       preamble_sel,
  input  logic       in_dat,
  input  logic       in_last,
  input  logic       in_vld,
  output logic       in_rdy,
  output logic       out_mod,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELIM = 3'd1,
    S_DATA0 = 3'd2,
    S_RTCAL = 3'd3,
    S_TRCAL = 3'd4,
    S_BITS  = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] L_TARI  = CNT_WIDTH'(TARI);
  localparam logic [CNT_WIDTH-1:0] L_DATA1 = CNT_WIDTH'(DATA1);
  localparam logic [CNT_WIDTH-1:0] L_PW    = CNT_WIDTH'(PW);
  localparam logic [CNT_WIDTH-1:0] L_DELIM = CNT_WIDTH'(DELIM);
  localparam logic [CNT_WIDTH-1:0] L_TRCAL = CNT_WIDTH'(TRCAL);
  localparam logic [CNT_WIDTH-1:0] L_RTCAL = CNT_WIDTH'(TARI + DATA1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   len_q, len_d;
  logic                   last_q, last_d;
  logic                   pre_q, pre_d;
  logic                   done_d, err_d;
  logic                   mod_d, busy_d, rdy_d;
  logic                   sym_end;
  logic                   take_fetch;

  assign dbg_state_o = state_q;

  // Next-state decode: symbol sequencing, bit fetch and frame termination.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + ONE;
    len_d      = len_q;
    last_d     = last_q;
    pre_d      = pre_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    take_fetch = 1'b0;
    sym_end    = (cnt_q == (len_q - ONE));

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_DELIM;
          len_d   = L_DELIM;
          pre_d   = preamble_sel;
        end
      end
      S_DELIM: begin
        if (sym_end) begin
          state_d = S_DATA0;
          cnt_d   = '0;
          len_d   = L_TARI;
        end
      end
      S_DATA0: begin
        if (sym_end) begin
          state_d = S_RTCAL;
          cnt_d   = '0;
          len_d   = L_RTCAL;
        end
      end
      S_RTCAL: begin
        if (sym_end) begin
          if (pre_q) begin
            state_d = S_TRCAL;
            cnt_d   = '0;
            len_d   = L_TRCAL;
          end else begin
            take_fetch = 1'b1;
          end
        end
      end
      S_TRCAL: begin
        if (sym_end) take_fetch = 1'b1;
      end
      S_BITS: begin
        if (sym_end) begin
          if (last_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            take_fetch = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // take_fetch coincides with the registered in_rdy strobe by construction.
    if (take_fetch) begin
      cnt_d = '0;
      if (in_vld) begin
        state_d = S_BITS;
        len_d   = in_dat ? L_DATA1 : L_TARI;
        last_d  = in_last;
      end else begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end
    end

    // Output values for the cycle described by the next state.
    busy_d = (state_d != S_IDLE);
    rdy_d  = (cnt_d == (len_d - ONE)) &&
             (((state_d == S_RTCAL) && !pre_d) ||
              (state_d == S_TRCAL) ||
              ((state_d == S_BITS) && !last_d));
    if (state_d == S_IDLE)       mod_d = 1'b1;
    else if (state_d == S_DELIM) mod_d = 1'b0;
    else                         mod_d = (cnt_d < (len_d - L_PW));
  end

  // State register and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= L_DELIM;
      last_q  <= 1'b0;
      pre_q   <= 1'b0;
      out_mod <= 1'b1;
      busy    <= 1'b0;
      in_rdy  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      last_q  <= last_d;
      pre_q   <= pre_d;
      out_mod <= mod_d;
      busy    <= busy_d;
      in_rdy  <= rdy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_pie_encoder.sv
// Bench for pie_encoder: per frame, the expected per-cycle output trace is
// built from the symbol timing and queued; each cycle one entry is popped
// and compared. Entry layout: {out_mod, busy, in_rdy, done, err}.
module tb_pie_encoder;

  localparam int W     = 5;
  localparam int TARI  = 8;
  localparam int DATA1 = 14;
  localparam int PW    = 4;
  localparam int DELIM = 6;
  localparam int TRCAL = 36;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       preamble_sel = 1'b0;
  logic       in_dat = 1'b0;
  logic       in_last = 1'b0;
  logic       in_vld = 1'b0;
  logic       in_rdy, out_mod, busy, done, err;
  logic [2:0] dbg_state;

  logic [W-1:0] exp_q[$];
  logic         bits_a[0:127];
  int           nbits;
  int           ur_idx;
  int           fetch_idx;
  int           vld_mode;
  int           hs_cnt;
  int           n_chk  = 0;
  int           n_pass = 0;

  pie_encoder #(
    .CNT_WIDTH(8), .TARI(TARI), .DATA1(DATA1), .PW(PW), .DELIM(DELIM), .TRCAL(TRCAL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .preamble_sel(preamble_sel),
    .in_dat(in_dat), .in_last(in_last), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_mod(out_mod), .busy(busy), .done(done), .err(err), .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // One symbol of length len: high for len-PW cycles, low for PW cycles.
  task automatic push_sym(input int len, input bit rdy_end);
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i < len - PW) ? 1'b1 : 1'b0, 1'b1,
                       (rdy_end && i == len - 1) ? 1'b1 : 1'b0, 1'b0, 1'b0});
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(5'b10000);
  endtask

  // Expected trace for cycles 1..end of frame, including the done/err cycle.
  task automatic build_frame(input bit pre, input int ur);
    ur_idx    = ur;
    fetch_idx = 0;
    for (int i = 0; i < DELIM; i++) exp_q.push_back(5'b01000);
    push_sym(TARI, 1'b0);
    push_sym(TARI + DATA1, !pre);
    if (pre) push_sym(TRCAL, 1'b1);
    for (int k = 0; k < nbits; k++) begin
      if (k == ur) break;
      push_sym(bits_a[k] ? DATA1 : TARI, k != nbits - 1);
    end
    exp_q.push_back({1'b1, 1'b0, 1'b0, (ur < 0) ? 1'b1 : 1'b0, (ur >= 0) ? 1'b1 : 1'b0});
  endtask

  // Raise start for the coming clock edge (immediately when back-to-back).
  task automatic begin_frame(input bit pre, input bit b2b);
    if (!b2b) begin
      @(posedge clk); #1;
    end
    start        = 1'b1;
    preamble_sel = pre;
    in_vld       = 1'b0;
  endtask

  // Drive the bit source and compare outputs until the expected queue empties.
  task automatic step_cycles(input string tag, input int rst_at, input int start_at);
    logic [W-1:0] e;
    int c;
    c = 1;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      start = (c == start_at);
      if (c == start_at) preamble_sel = 1'b1;
      rst = (c == rst_at);
      e = exp_q[0];
      if (e[2]) begin
        in_vld    = (fetch_idx != ur_idx);
        in_dat    = bits_a[fetch_idx];
        in_last   = (fetch_idx == nbits - 1);
        fetch_idx++;
      end else begin
        in_vld  = (vld_mode == 1) ? 1'b1 : (vld_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        in_dat  = 1'($urandom_range(0, 1));
        in_last = 1'b0;
      end
      @(negedge clk);
      if (in_rdy && in_vld) hs_cnt++;
      check_val($sformatf("%s c%0d", tag, c), {27'd0, out_mod, busy, in_rdy, done, err},
                {27'd0, exp_q.pop_front()});
      if (c == rst_at) begin
        exp_q.delete();
        push_idle(3);
      end
      c++;
    end
    start  = 1'b0;
    rst    = 1'b0;
    in_vld = 1'b0;
  endtask

  task automatic set_s1_bits();
    nbits = 2; bits_a[0] = 1'b1; bits_a[1] = 1'b0;
  endtask

  initial begin
    vld_mode = 1;
    hs_cnt   = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset outputs", {27'd0, out_mod, busy, in_rdy, done, err}, 32'h10);
    check_val("reset state", {29'd0, dbg_state}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    push_idle(3);
    ur_idx = -1; fetch_idx = 0; nbits = 0;
    step_cycles("idle", -1, -1);

    // Frame-sync, bits 1,0
    set_s1_bits();
    begin_frame(1'b0, 1'b0); build_frame(1'b0, -1); push_idle(3);
    step_cycles("s1", -1, -1);

    // Preamble, single bit 0
    nbits = 1; bits_a[0] = 1'b0;
    begin_frame(1'b1, 1'b0); build_frame(1'b1, -1); push_idle(3);
    step_cycles("s2", -1, -1);

    // Underrun on first fetch, then on a mid-frame fetch
    vld_mode = 0;
    set_s1_bits();
    begin_frame(1'b0, 1'b0); build_frame(1'b0, 0); push_idle(3);
    step_cycles("s3a", -1, -1);
    nbits = 4; bits_a[0] = 1'b0; bits_a[1] = 1'b1; bits_a[2] = 1'b1; bits_a[3] = 1'b0;
    begin_frame(1'b1, 1'b0); build_frame(1'b1, 2); push_idle(3);
    step_cycles("s3b", -1, -1);
    vld_mode = 1;

    // Start while busy is ignored; start in the done cycle chains a frame
    set_s1_bits();
    begin_frame(1'b0, 1'b0); build_frame(1'b0, -1); push_idle(3);
    step_cycles("s4a", -1, 20);
    begin_frame(1'b0, 1'b0); build_frame(1'b0, -1);
    step_cycles("s4b1", -1, -1);
    begin_frame(1'b0, 1'b1); build_frame(1'b0, -1); push_idle(3);
    step_cycles("s4b2", -1, -1);

    // Reset mid-frame, then a fresh frame
    begin_frame(1'b0, 1'b0); build_frame(1'b0, -1);
    step_cycles("s5rst", 12, -1);
    begin_frame(1'b0, 1'b0); build_frame(1'b0, -1); push_idle(3);
    step_cycles("s5", -1, -1);

    // Long random stream with random in_vld between fetches
    vld_mode = 2;
    nbits = 64;
    for (int i = 0; i < 64; i++) bits_a[i] = 1'($urandom_range(0, 1));
    hs_cnt = 0;
    begin_frame(1'b1, 1'b0); build_frame(1'b1, -1); push_idle(3);
    step_cycles("s6", -1, -1);
    check_val("s6 handshakes", hs_cnt, 32'd64);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pie_encoder.md
Name: pie_encoder

Overview:
- Reader-to-tag transmit encoder for the EPC Gen2 forward link. It is the transmit-side counterpart of the backscatter bit detector.
- Takes a serial command bit stream through a valid/ready handshake and produces the PIE-modulated carrier-enable signal out_mod (1 = full CW, 0 = attenuated).
- Prepends a delimiter and a preamble (with TRcal) or a frame-sync (without TRcal).
- Sits between the command builder and the DAC/modulator control.

Parameters:
- CNT_WIDTH, 8: width of the symbol-length counter; every length parameter below must be < 2^CNT_WIDTH.
- TARI, 8: data-0 symbol length in clk cycles.
- DATA1, 14: data-1 symbol length in clk cycles (1.5 to 2 x TARI).
- PW, 4: low-pulse width at the end of every symbol, in cycles; 0 < PW < TARI.
- DELIM, 6: delimiter low duration in cycles.
- TRCAL, 36: TRcal symbol length in cycles. RTcal is fixed at TARI+DATA1.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- start, input, 1: begin a frame; sampled only in IDLE.
- preamble_sel, input, 1: captured with start; 1 = preamble (includes TRcal), 0 = frame-sync.
- in_dat, input, 1: next command bit.
- in_last, input, 1: qualifies in_dat as the final bit of the frame.
- in_vld, input, 1: bit-source valid.
- in_rdy, output, 1: encoder fetch strobe; a transfer occurs when in_vld and in_rdy are both high.
- out_mod, output, 1: registered modulation output.
- busy, output, 1: high while a frame is being emitted.
- done, output, 1: one-cycle pulse when a frame completes normally.
- err, output, 1: one-cycle pulse when a frame is aborted on underrun.

Behaviour:
- Reset: out_mod=1, busy=0, done=0, err=0, in_rdy=0, FSM in IDLE, counter 0. Reset mid-frame aborts the frame: out_mod=1 on the next cycle, no done or err pulse.
- FSM states: IDLE -> DELIM -> DATA0 -> RTCAL -> (TRCAL if preamble_sel captured as 1) -> BITS -> IDLE.
- start while not in IDLE is ignored. preamble_sel is latched on the start cycle.
- Cycle numbering: the start-sample cycle is cycle 0. Frame output begins at cycle 1. busy=1 from cycle 1 through the last low cycle of the final symbol.
- DELIM: out_mod=0 for DELIM cycles.
- Generic symbol of length L (DATA0 = TARI, RTCAL = TARI+DATA1, TRCAL = TRCAL, data bit = TARI or DATA1): out_mod=1 for L-PW cycles, then 0 for PW cycles. The counter runs 0..L-1 and wraps at the symbol boundary; symbols abut with no gap.
- Fetch cycle: the last cycle of the RTcal symbol (frame-sync), the TRcal symbol (preamble), or any data symbol not marked last.
  - in_rdy is high for exactly that cycle and low otherwise.
  - If in_vld=1, in_dat and in_last are consumed; the new symbol starts on the next cycle (0 -> TARI, 1 -> DATA1).
- Underrun: in_vld=0 on a fetch cycle.
  - Next cycle: out_mod=1, err=1 for one cycle, busy=0, state IDLE.
  - The source must not offer further bits for the aborted frame.
- Completion: after the last cycle of a symbol whose bit had in_last=1:
  - Next cycle: out_mod=1, done=1 for one cycle, busy=0, state IDLE.
  - A start in that same cycle is accepted as a new frame (back-to-back frames).
- in_rdy is never asserted in IDLE, DELIM, DATA0, or the non-final cycles of any symbol.
- Frames carry at least one bit; zero-length frames are not supported.
- Counter compare is unsigned at CNT_WIDTH. Symbol lengths are static parameters; there is no runtime change.

Test Plan (default parameters; cycle 0 = start sampled):
1. Frame-sync, bits 1,0 (second bit last), in_vld held high:
   - out_mod low at cycles 1-6, high 7-10, low 11-14, high 15-32, low 33-36.
   - in_rdy at cycle 36 (bit 1): high 37-46, low 47-50.
   - in_rdy at cycle 50 (bit 0): high 51-54, low 55-58.
   - done=1 and busy=0 at cycle 59; out_mod stays 1 afterwards.
2. Preamble, single bit 0 with in_last:
   - RTcal as in scenario 1, then TRcal high 37-68, low 69-72.
   - in_rdy at cycle 72; data-0 symbol at 73-80; done at cycle 81.
3. Underrun:
   - Frame-sync with in_vld=0 at cycle 36 -> cycle 37 out_mod=1, err=1, busy=0, no done.
   - Repeat with underrun on a mid-frame fetch; the same abort behaviour is required.
4. Start while busy:
   - Pulse start at cycle 20 of scenario 1 -> frame timing unchanged, no second frame.
   - Start in the done cycle -> new delimiter begins the following cycle.
5. Reset mid-frame:
   - Assert rst at cycle 12 -> out_mod=1 and busy=0 from cycle 13, no done or err, in_rdy=0.
   - A fresh start after reset reproduces scenario 1 timing exactly.
6. Long random bit stream (64 bits, random in_vld gaps between fetches, valid always high on fetch cycles):
   - Decoded pulse intervals match the input bits; no gaps between symbols.
   - in_rdy count equals the bit count.
